key_matrix_emu: RTL and testbench

KEY_MATRIX_EMU -- requirements
Module: key_matrix_emu

---
 rtl/key_emu_pkg.sv | 28 ++
 rtl/ms_down_cnt.sv | 29 ++
 rtl/key_matrix_emu.sv | 169 ++++++++++++++++
 tb/tb_key_matrix_emu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_emu_pkg.sv
// Shared constants, state type and key-index helpers for the key-matrix emulator.
package key_emu_pkg;

  localparam int KEY_ROWS = 5;
  localparam int KEY_COLS = 4;
  localparam int KEY_NUM  = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_GAP    = 2'd3
  } key_state_t;

  // Key index is row*4 + col, so the column sits in the low two bits.
  function automatic logic [2:0] code_row(input logic [4:0] code);
    return code[4:2];
  endfunction

  function automatic logic [1:0] code_col(input logic [4:0] code);
    return code[1:0];
  endfunction

  function automatic logic code_valid(input logic [4:0] code);
    return code < 5'(KEY_NUM);
  endfunction

endpackage

// File: rtl/ms_down_cnt.sv
// Millisecond down-counter shared by the BOUNCE, HOLD and GAP phases.
module ms_down_cnt #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_pls_1k,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_pls_1k && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // High on the strobe that brings the count to zero, so the owning phase ends on that strobe.
  assign o_zero = i_pls_1k && (r_cnt <= W'(1));

endmodule

// File: rtl/key_matrix_emu.sv
// Emulates one key press on a 5x4 active-low keypad matrix driven by an external scanner.
// Optional contact bounce before the hold phase is enabled with `define KEY_EMU_BOUNCE_EN.
module key_matrix_emu
  import key_emu_pkg::*;
#(
  parameter int HOLD_MS_W = 10,
  parameter int GAP_MS    = 20,
  parameter int BOUNCE_MS = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pls_1k,
  input  logic                 i_req,
  input  logic [4:0]           i_code,
  input  logic [HOLD_MS_W-1:0] i_hold_ms,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  input  logic [3:0]           i_key_out,
  output logic [4:0]           o_key_in
);

  key_state_t           r_state;
  logic [4:0]           r_code;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [4:0]           r_key_in;

  logic                 w_accept;
  logic                 w_contact;
  logic                 w_load;
  logic [HOLD_MS_W-1:0] w_load_val;
  logic [HOLD_MS_W-1:0] w_hold_eff;
  logic                 w_cnt_zero;

`ifdef KEY_EMU_BOUNCE_EN
  logic [HOLD_MS_W-1:0] r_hold;
  logic                 r_bounce_closed;
`else
  logic                 w_unused_bounce;
  assign w_unused_bounce = (BOUNCE_MS != 0);
`endif

  assign w_accept   = (r_state == ST_IDLE) && i_req && code_valid(i_code);
  // A zero hold request still closes the contact for one strobe.
  assign w_hold_eff = (i_hold_ms == '0) ? HOLD_MS_W'(1) : i_hold_ms;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
`ifdef KEY_EMU_BOUNCE_EN
          w_load_val = HOLD_MS_W'(BOUNCE_MS);
`else
          w_load_val = w_hold_eff;
`endif
        end
      end
`ifdef KEY_EMU_BOUNCE_EN
      ST_BOUNCE: begin
        if (w_cnt_zero) begin
          w_load     = 1'b1;
          w_load_val = r_hold;
        end
      end
`endif
      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_load     = 1'b1;
          w_load_val = HOLD_MS_W'(GAP_MS);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_contact = (r_state == ST_HOLD);
`ifdef KEY_EMU_BOUNCE_EN
    if (r_state == ST_BOUNCE) w_contact = r_bounce_closed;
`endif
  end

  ms_down_cnt #(
    .W (HOLD_MS_W)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_pls_1k   (i_pls_1k),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_code   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_key_in <= 5'b11111;
`ifdef KEY_EMU_BOUNCE_EN
      r_hold          <= '0;
      r_bounce_closed <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      // Only the latched key's row can be pulled low, and only when its column is being scanned.
      r_key_in <= 5'b11111;
      if (w_contact && !i_key_out[code_col(r_code)]) begin
        r_key_in[code_row(r_code)] <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            if (!code_valid(i_code)) begin
              r_err <= 1'b1;
            end else begin
              r_code <= i_code;
              r_busy <= 1'b1;
`ifdef KEY_EMU_BOUNCE_EN
              r_hold          <= w_hold_eff;
              r_bounce_closed <= 1'b1;
              r_state         <= ST_BOUNCE;
`else
              r_state <= ST_HOLD;
`endif
            end
          end
        end
`ifdef KEY_EMU_BOUNCE_EN
        ST_BOUNCE: begin
          if (w_cnt_zero) begin
            r_state <= ST_HOLD;
          end else if (i_pls_1k) begin
            r_bounce_closed <= ~r_bounce_closed;
          end
        end
`endif
        ST_HOLD: begin
          if (w_cnt_zero) r_state <= ST_GAP;
        end
        ST_GAP: begin
          if (w_cnt_zero) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_key_in = r_key_in;

endmodule

// File: tb/tb_key_matrix_emu.sv
// Self-checking bench for key_matrix_emu (default build, bounce disabled).
module tb_key_matrix_emu;

  localparam int GAP     = 20;
  localparam int PLS_DIV = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_pls_1k = 1'b0;
  logic       i_req = 1'b0;
  logic [4:0] i_code = '0;
  logic [9:0] i_hold_ms = '0;
  logic [3:0] i_key_out = 4'hF;
  logic       o_busy, o_done, o_err;
  logic [4:0] o_key_in;

  int n_total = 0;
  int n_bad   = 0;

  always #5 i_clk = ~i_clk;

  key_matrix_emu dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_pls_1k  (i_pls_1k),
    .i_req     (i_req),
    .i_code    (i_code),
    .i_hold_ms (i_hold_ms),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .i_key_out (i_key_out),
    .o_key_in  (o_key_in)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe every PLS_DIV cycles; column scan either rotating one-hot-low or a fixed pattern.
  bit         scan_en = 1'b0;
  logic [3:0] kout_fixed = 4'hF;
  int         div_cnt = 0;
  int         scan_idx = 0;
  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      i_pls_1k = (div_cnt == PLS_DIV - 1);
      div_cnt  = (div_cnt + 1) % PLS_DIV;
      if (scan_en) begin
        i_key_out = ~(4'b0001 << scan_idx);
        scan_idx  = (scan_idx + 1) % 4;
      end else begin
        i_key_out = kout_fixed;
      end
    end
  end

  // Model: a press is a strobe count since acceptance; contact is closed for the first
  // hold strobes, and the press finishes after hold + GAP strobes.
  bit         m_busy;
  int         m_code, m_hold, m_strobes;
  logic [3:0] m_kout;
  logic [4:0] e_key_in;
  logic       e_busy, e_done, e_err;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_busy = 0; m_code = 0; m_hold = 0; m_strobes = 0; m_kout = 4'hF;
      e_key_in = 5'h1F; e_busy = 0; e_done = 0; e_err = 0;
    end else begin
      m_kout   = i_key_out;
      e_key_in = 5'h1F;
      if (m_busy && (m_strobes < m_hold) && !i_key_out[m_code % 4]) e_key_in[m_code / 4] = 1'b0;
      e_done = 0;
      e_err  = 0;
      if (!m_busy) begin
        if (i_req) begin
          if (i_code >= 20) begin
            e_err = 1;
          end else begin
            m_busy    = 1;
            m_code    = int'(i_code);
            m_hold    = (i_hold_ms == 0) ? 1 : int'(i_hold_ms);
            m_strobes = 0;
          end
        end
      end else if (i_pls_1k) begin
        m_strobes++;
        if (m_strobes == m_hold + GAP) begin
          e_done = 1;
          m_busy = 0;
        end
      end
      e_busy = m_busy;
    end
  end

  // Per-cycle compare plus event counters used by the directed checks.
  int n_done = 0, n_err = 0, n_busy = 0, n_keyact = 0;
  int n_11101 = 0, n_other = 0, n_mis1011 = 0;
  int n_low [5] = '{default: 0};

  always @(negedge i_clk) begin
    if (!i_rst) begin
      check("key_in", {27'd0, o_key_in}, {27'd0, e_key_in});
      check("busy", {31'd0, o_busy}, {31'd0, e_busy});
      check("done", {31'd0, o_done}, {31'd0, e_done});
      check("err", {31'd0, o_err}, {31'd0, e_err});
      n_done += int'(o_done);
      n_err  += int'(o_err);
      n_busy += int'(o_busy);
      if (o_key_in != 5'h1F) n_keyact++;
      for (int r = 0; r < 5; r++) if (!o_key_in[r]) n_low[r]++;
      if (o_key_in == 5'b11101) begin
        n_11101++;
        if (m_kout != 4'b1011) n_mis1011++;
      end else if (o_key_in != 5'h1F) begin
        n_other++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  task automatic req(input logic [4:0] code, input logic [9:0] hold);
    i_req     = 1'b1;
    i_code    = code;
    i_hold_ms = hold;
    tick(1);
    i_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!o_done && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    check(name, {31'd0, o_done}, 32'd1);
    tick(1);
  endtask

  int b_done, b_err, b_busy, b_act, b_11101, b_other, b_mis, b_low0, b_low4;

  initial begin
    // Reset state
    tick(3);
    check("rst_key_in", {27'd0, o_key_in}, 32'h1F);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    i_rst = 1'b0;
    tick(2);

    // Column scan, code 6 (row1 col2), hold 3; inputs changed after acceptance must not matter
    b_done = n_done; b_11101 = n_11101; b_other = n_other; b_mis = n_mis1011;
    scan_en = 1'b1;
    req(5'd6, 10'd3);
    i_code = 5'd0; i_hold_ms = 10'd50;
    wait_done("scan_done_seen", 400);
    check("scan_row1_low_seen", {31'd0, (n_11101 - b_11101) >= 2}, 32'd1);
    check("scan_other_rows", n_other - b_other, 32'd0);
    check("scan_low_only_col2", n_mis1011 - b_mis, 32'd0);
    check("scan_one_done", n_done - b_done, 32'd1);
    scan_en = 1'b0;
    kout_fixed = 4'b0000;
    tick(4);

    // Invalid codes: one err pulse each, no busy, key lines idle
    b_err = n_err; b_busy = n_busy; b_act = n_keyact;
    req(5'd20, 10'd5);
    tick(3);
    check("inv20_err_once", n_err - b_err, 32'd1);
    req(5'd31, 10'd5);
    tick(3);
    check("inv31_err_once", n_err - b_err, 32'd2);
    check("inv_no_busy", n_busy - b_busy, 32'd0);
    check("inv_key_idle", n_keyact - b_act, 32'd0);

    // Request during HOLD is ignored; code 9 is row2 col1
    b_done = n_done; b_low0 = n_low[0];
    req(5'd9, 10'd4);
    tick(3);
    req(5'd0, 10'd2);
    wait_done("busy_done_seen", 400);
    tick(12);
    check("busy_no_row0", n_low[0] - b_low0, 32'd0);
    check("busy_one_done", n_done - b_done, 32'd1);
    check("busy_not_queued", {31'd0, o_busy}, 32'd0);

    // Zero hold on boundary code 19 (row4 col3), all columns low: closed for exactly one strobe
    b_low4 = n_low[4];
    req(5'd19, 10'd0);
    wait_done("zero_done_seen", 400);
    check("zero_row4_low_seen", {31'd0, (n_low[4] - b_low4) >= 1}, 32'd1);
    check("zero_row4_low_le_1ms", {31'd0, (n_low[4] - b_low4) <= PLS_DIV}, 32'd1);
    tick(3);

    // Reset in HOLD releases the key at once and suppresses done
    b_done = n_done;
    req(5'd5, 10'd10);
    tick(6);
    check("pre_rst_row1_low", {31'd0, o_key_in[1]}, 32'd0);
    i_rst = 1'b1;
    #1;
    check("async_rst_key_in", {27'd0, o_key_in}, 32'h1F);
    check("async_rst_busy", {31'd0, o_busy}, 32'd0);
    tick(1);
    i_rst = 1'b0;
    tick(150);
    check("rst_no_done", n_done - b_done, 32'd0);
    req(5'd2, 10'd1);
    check("rst_new_accept", {31'd0, o_busy}, 32'd1);
    wait_done("rst_new_done", 400);
    check("rst_new_one_done", n_done - b_done, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
